jtag_tap_bridge: RTL

Second-generation JTAG TAP with a parametrised management bus bridge, clocked entirely from the core clock by oversampling TCK. It replaces the fixed 5-bit-IR / 20-bit-address TAP. It adds separate command, data and status data registers, a busy/wait handshake on the management bus, sticky error reporting, and standards-compliant TDO timing on the falling edge of TCK. It sits between the chip-level JTAG pins and the core management port.

---
 rtl/jtag_tap_bridge.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_bridge.sv
// JTAG TAP oversampled on the core clock, bridging CMD/DATA/STATUS scan registers
// onto a management bus with a busy/wait handshake and sticky error flags.
module jtag_tap_bridge #(
    parameter int IR_WIDTH   = 5,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             coreID,
    input  logic [10:0]             manufacturerID,
    input  logic [15:0]             partID,
    input  logic [3:0]              versionID,
    input  logic                    jtag_tck,
    input  logic                    jtag_tms,
    input  logic                    jtag_tdi,
    output logic                    jtag_tdo,
    output logic                    management_enable,
    output logic                    management_writeEnable,
    output logic [DATA_WIDTH/8-1:0] management_byteSelect,
    output logic [ADDR_WIDTH-1:0]   management_address,
    output logic [DATA_WIDTH-1:0]   management_writeData,
    input  logic [DATA_WIDTH-1:0]   management_readData,
    input  logic                    management_busy,
    output logic [IR_WIDTH-1:0]     probe_jtagInstruction
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = ADDR_WIDTH + BW + 2;
    localparam logic [IR_WIDTH-1:0] IR_IDCODE   = IR_WIDTH'(4);
    localparam logic [IR_WIDTH-1:0] IR_USERCODE = IR_WIDTH'(3);
    localparam logic [IR_WIDTH-1:0] IR_CMD      = IR_WIDTH'(8);
    localparam logic [IR_WIDTH-1:0] IR_DATA     = IR_WIDTH'(9);
    localparam logic [IR_WIDTH-1:0] IR_STATUS   = IR_WIDTH'(10);

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR,
        TAP_UP_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UP_IR
    } tap_t;

    typedef enum logic [1:0] {M_IDLE, M_WAIT_DATA, M_BUS_READ, M_BUS_WRITE} mgmt_t;

    logic [1:0] r_tck_sync, r_tms_sync, r_tdi_sync;
    logic       r_tck_prev;
    logic       w_tck_rise, w_tck_fall, w_tms, w_tdi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tck_sync <= '0;
            r_tms_sync <= '0;
            r_tdi_sync <= '0;
            r_tck_prev <= 1'b0;
        end else begin
            r_tck_sync <= {r_tck_sync[0], jtag_tck};
            r_tms_sync <= {r_tms_sync[0], jtag_tms};
            r_tdi_sync <= {r_tdi_sync[0], jtag_tdi};
            r_tck_prev <= r_tck_sync[1];
        end
    end

    assign w_tck_rise = r_tck_sync[1] & ~r_tck_prev;
    assign w_tck_fall = ~r_tck_sync[1] & r_tck_prev;
    assign w_tms      = r_tms_sync[1];
    assign w_tdi      = r_tdi_sync[1];

    tap_t r_tap, w_tap_nxt;

    always_ff @(posedge clk) begin
        if (rst)             r_tap <= TAP_TLR;
        else if (w_tck_rise) r_tap <= w_tap_nxt;
    end

    always_comb begin
        w_tap_nxt = r_tap;
        case (r_tap)
            TAP_TLR:    w_tap_nxt = w_tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    w_tap_nxt = w_tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: w_tap_nxt = w_tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: w_tap_nxt = w_tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  w_tap_nxt = w_tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: w_tap_nxt = w_tms ? TAP_UP_DR  : TAP_PA_DR;
            TAP_PA_DR:  w_tap_nxt = w_tms ? TAP_EX2_DR : TAP_PA_DR;
            TAP_EX2_DR: w_tap_nxt = w_tms ? TAP_UP_DR  : TAP_SH_DR;
            TAP_UP_DR:  w_tap_nxt = w_tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: w_tap_nxt = w_tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: w_tap_nxt = w_tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  w_tap_nxt = w_tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: w_tap_nxt = w_tms ? TAP_UP_IR  : TAP_PA_IR;
            TAP_PA_IR:  w_tap_nxt = w_tms ? TAP_EX2_IR : TAP_PA_IR;
            TAP_EX2_IR: w_tap_nxt = w_tms ? TAP_UP_IR  : TAP_SH_IR;
            TAP_UP_IR:  w_tap_nxt = w_tms ? TAP_SEL_DR : TAP_RTI;
        endcase
    end

    // Register actions fire on the TCK rise that leaves the named state.
    logic w_cap_ir, w_sh_ir, w_up_ir, w_cap_dr, w_sh_dr, w_up_dr;
    assign w_cap_ir = w_tck_rise && r_tap == TAP_CAP_IR;
    assign w_sh_ir  = w_tck_rise && r_tap == TAP_SH_IR;
    assign w_up_ir  = w_tck_rise && r_tap == TAP_UP_IR;
    assign w_cap_dr = w_tck_rise && r_tap == TAP_CAP_DR;
    assign w_sh_dr  = w_tck_rise && r_tap == TAP_SH_DR;
    assign w_up_dr  = w_tck_rise && r_tap == TAP_UP_DR;

    logic [IR_WIDTH-1:0] r_ir_sr, r_cur_ir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_sr  <= '0;
            r_cur_ir <= IR_IDCODE;
        end else begin
            if (w_cap_ir)     r_ir_sr <= IR_WIDTH'(2'b01);
            else if (w_sh_ir) r_ir_sr <= {w_tdi, r_ir_sr[IR_WIDTH-1:1]};
            if (r_tap == TAP_TLR) r_cur_ir <= IR_IDCODE;
            else if (w_up_ir)     r_cur_ir <= r_ir_sr;
        end
    end

    logic w_sel_id, w_sel_cmd, w_sel_data, w_sel_stat, w_sel_byp;
    assign w_sel_id   = (r_cur_ir == IR_IDCODE) || (r_cur_ir == IR_USERCODE);
    assign w_sel_cmd  = r_cur_ir == IR_CMD;
    assign w_sel_data = r_cur_ir == IR_DATA;
    assign w_sel_stat = r_cur_ir == IR_STATUS;
    assign w_sel_byp  = !(w_sel_id || w_sel_cmd || w_sel_data || w_sel_stat);

    mgmt_t                  r_m, w_m_nxt;
    logic [31:0]            r_id_sr;
    logic                   r_byp_sr;
    logic [CW-1:0]          r_cmd_sr;
    logic [DATA_WIDTH-1:0]  r_data_sr, r_rdata, r_wdata;
    logic [3:0]             r_stat_sr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [BW-1:0]          r_bsel;
    logic                   r_overrun, r_error, r_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_sr   <= '0;
            r_byp_sr  <= 1'b0;
            r_cmd_sr  <= '0;
            r_data_sr <= '0;
            r_stat_sr <= '0;
        end else if (w_cap_dr) begin
            if (w_sel_id)   r_id_sr   <= (r_cur_ir == IR_USERCODE) ? coreID
                                         : {versionID, partID, manufacturerID, 1'b1};
            if (w_sel_byp)  r_byp_sr  <= 1'b0;
            if (w_sel_cmd)  r_cmd_sr  <= '0;
            if (w_sel_data) r_data_sr <= r_rdata;
            if (w_sel_stat) r_stat_sr <= {r_overrun, r_error, r_rvalid, r_m != M_IDLE};
        end else if (w_sh_dr) begin
            if (w_sel_id)   r_id_sr   <= {w_tdi, r_id_sr[31:1]};
            if (w_sel_byp)  r_byp_sr  <= w_tdi;
            if (w_sel_cmd)  r_cmd_sr  <= {w_tdi, r_cmd_sr[CW-1:1]};
            if (w_sel_data) r_data_sr <= {w_tdi, r_data_sr[DATA_WIDTH-1:1]};
            if (w_sel_stat) r_stat_sr <= {w_tdi, r_stat_sr[3:1]};
        end
    end

    logic w_dr_lsb;
    always_comb begin
        w_dr_lsb = r_byp_sr;
        if (w_sel_id)   w_dr_lsb = r_id_sr[0];
        if (w_sel_cmd)  w_dr_lsb = r_cmd_sr[0];
        if (w_sel_data) w_dr_lsb = r_data_sr[0];
        if (w_sel_stat) w_dr_lsb = r_stat_sr[0];
    end

    always_ff @(posedge clk) begin
        if (rst) jtag_tdo <= 1'b0;
        else if (w_tck_fall) begin
            case (r_tap)
                TAP_SH_IR: jtag_tdo <= r_ir_sr[0];
                TAP_SH_DR: jtag_tdo <= w_dr_lsb;
                default:   jtag_tdo <= 1'b0;
            endcase
        end
    end

    logic          w_upd_cmd, w_upd_data, w_cap_data, w_cap_stat;
    logic          w_cmd_rd, w_cmd_wr;
    logic [BW-1:0] w_cmd_bsel;
    assign w_upd_cmd  = w_up_dr  && w_sel_cmd;
    assign w_upd_data = w_up_dr  && w_sel_data;
    assign w_cap_data = w_cap_dr && w_sel_data;
    assign w_cap_stat = w_cap_dr && w_sel_stat;
    assign w_cmd_rd   = r_cmd_sr[CW-1];
    assign w_cmd_wr   = r_cmd_sr[CW-2];
    assign w_cmd_bsel = r_cmd_sr[ADDR_WIDTH +: BW];

    logic w_lat_cmd, w_lat_wd, w_set_err, w_set_ovr, w_done;

    always_ff @(posedge clk) begin
        if (rst) r_m <= M_IDLE;
        else     r_m <= w_m_nxt;
    end

    always_comb begin
        w_m_nxt   = r_m;
        w_lat_cmd = 1'b0;
        w_lat_wd  = 1'b0;
        w_set_err = 1'b0;
        w_set_ovr = 1'b0;
        w_done    = 1'b0;
        case (r_m)
            M_IDLE: begin
                if (w_upd_cmd) begin
                    if ((w_cmd_rd || w_cmd_wr) && ((w_cmd_rd && w_cmd_wr) || w_cmd_bsel == '0)) begin
                        w_set_err = 1'b1;
                    end else if (w_cmd_rd) begin
                        w_lat_cmd = 1'b1;
                        w_m_nxt   = M_BUS_READ;
                    end else if (w_cmd_wr) begin
                        w_lat_cmd = 1'b1;
                        w_m_nxt   = M_WAIT_DATA;
                    end
                end
            end
            M_WAIT_DATA: begin
                if (w_upd_cmd) begin
                    w_set_ovr = 1'b1;
                    w_m_nxt   = M_IDLE;
                end else if (w_upd_data) begin
                    w_lat_wd = 1'b1;
                    w_m_nxt  = M_BUS_WRITE;
                end
            end
            M_BUS_READ, M_BUS_WRITE: begin
                w_set_ovr = w_upd_cmd || w_upd_data;
                if (!management_busy) begin
                    w_done  = 1'b1;
                    w_m_nxt = M_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_bsel    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_overrun <= 1'b0;
            r_error   <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            if (w_lat_cmd) begin
                r_addr <= r_cmd_sr[ADDR_WIDTH-1:0];
                r_bsel <= w_cmd_bsel;
            end
            if (w_lat_wd) r_wdata <= r_data_sr;
            if (w_done && r_m == M_BUS_READ) r_rdata <= management_readData;
            if (w_cap_stat) begin
                r_overrun <= 1'b0;
                r_error   <= 1'b0;
            end
            if (w_set_err) r_error   <= 1'b1;
            if (w_set_ovr) r_overrun <= 1'b1;
            // A completion landing on the DATA capture wins so the new data is not lost.
            if (w_cap_data) r_rvalid <= 1'b0;
            if (w_done && r_m == M_BUS_READ) r_rvalid <= 1'b1;
        end
    end

    assign management_enable      = (r_m == M_BUS_READ) || (r_m == M_BUS_WRITE);
    assign management_writeEnable = r_m == M_BUS_WRITE;
    assign management_writeData   = (r_m == M_BUS_WRITE) ? r_wdata : '0;
    assign management_address     = r_addr;
    assign management_byteSelect  = r_bsel;
    assign probe_jtagInstruction  = r_cur_ir;
endmodule
